// File: rtl/video_timing_pkg.sv
// 640x480 raster constants and counter sizing helpers shared by the video timing generator.
package video_timing_pkg;

    localparam int unsigned MODE_H_VISIBLE = 640;
    localparam int unsigned MODE_H_FRONT   = 16;
    localparam int unsigned MODE_H_SYNC    = 96;
    localparam int unsigned MODE_H_BACK    = 48;

    localparam int unsigned MODE_V_VISIBLE = 480;
    localparam int unsigned MODE_V_FRONT   = 10;
    localparam int unsigned MODE_V_SYNC    = 2;
    localparam int unsigned MODE_V_BACK    = 33;

    localparam int unsigned MODE_H_TOTAL =
        MODE_H_VISIBLE + MODE_H_FRONT + MODE_H_SYNC + MODE_H_BACK;
    localparam int unsigned MODE_V_TOTAL =
        MODE_V_VISIBLE + MODE_V_FRONT + MODE_V_SYNC + MODE_V_BACK;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: position counter with advance-enable and wrap, plus region decode flags.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned VISIBLE = MODE_H_VISIBLE,
    parameter int unsigned FRONT   = MODE_H_FRONT,
    parameter int unsigned SYNC    = MODE_H_SYNC,
    parameter int unsigned BACK    = MODE_H_BACK,
    localparam int unsigned TOTAL  = VISIBLE + FRONT + SYNC + BACK,
    localparam int unsigned W      = cnt_w(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         adv_i,
    output logic [W-1:0] pos_o,
    output logic         active_o,
    output logic         sync_o,
    output logic         wrap_o,
    output logic         at_visible_o
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END    = W'(VISIBLE);
    localparam logic [W-1:0] SYNC_FIRST = W'(VISIBLE + FRONT);
    localparam logic [W-1:0] SYNC_LAST  = W'(VISIBLE + FRONT + SYNC - 1);

    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;

    always_comb begin
        pos_d = pos_q;
        if (adv_i) begin
            pos_d = wrap_o ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o        = pos_q;
    assign wrap_o       = (pos_q == LAST);
    assign active_o     = (pos_q < VIS_END);
    assign at_visible_o = (pos_q == VIS_END);
    assign sync_o       = (pos_q >= SYNC_FIRST) && (pos_q <= SYNC_LAST);

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source with pixel prescaler; VIDEO_TIMING_COORDS_EN adds registered x_o/y_o.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int unsigned CLKS_PER_PIXEL = 2,
    parameter int unsigned H_VISIBLE      = MODE_H_VISIBLE,
    parameter int unsigned H_FRONT        = MODE_H_FRONT,
    parameter int unsigned H_SYNC         = MODE_H_SYNC,
    parameter int unsigned H_BACK         = MODE_H_BACK,
    parameter int unsigned V_VISIBLE      = MODE_V_VISIBLE,
    parameter int unsigned V_FRONT        = MODE_V_FRONT,
    parameter int unsigned V_SYNC         = MODE_V_SYNC,
    parameter int unsigned V_BACK         = MODE_V_BACK,
    localparam int unsigned H_TOTAL       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW            = cnt_w(H_TOTAL),
    localparam int unsigned VW            = cnt_w(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          end_of_frame_o,
    output logic          end_of_visible_line_o,
    output logic          hsync_n_o,
    output logic          vsync_n_o,
    output logic          visible_o
`ifdef VIDEO_TIMING_COORDS_EN
    ,
    output logic [HW-1:0] x_o,
    output logic [VW-1:0] y_o
`endif
);

    localparam int unsigned DIV_W = cnt_w(CLKS_PER_PIXEL);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_PIXEL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    logic             visible_q, visible_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;
    logic             hsync_n_q, hsync_n_d;
    logic             vsync_n_q, vsync_n_d;

    logic [HW-1:0]    h_pos;
    logic             h_active, h_sync, h_wrap, h_at_visible;
    logic [VW-1:0]    v_pos;
    logic             v_active, v_sync, v_wrap, v_at_visible;

    assign tick = (div_q == DIV_LAST);

    video_timing_axis #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .adv_i        (tick),
        .pos_o        (h_pos),
        .active_o     (h_active),
        .sync_o       (h_sync),
        .wrap_o       (h_wrap),
        .at_visible_o (h_at_visible)
    );

    // Vertical position steps once per line, on the tick that wraps h.
    video_timing_axis #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .adv_i        (tick & h_wrap),
        .pos_o        (v_pos),
        .active_o     (v_active),
        .sync_o       (v_sync),
        .wrap_o       (v_wrap),
        .at_visible_o (v_at_visible)
    );

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        visible_d = tick & h_active & v_active;
        eol_d     = tick & h_at_visible & v_active;
        eof_d     = tick & (h_pos == '0) & v_at_visible;
        hsync_n_d = tick ? ~h_sync : hsync_n_q;
        vsync_n_d = tick ? ~v_sync : vsync_n_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q     <= '0;
            visible_q <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
        end else begin
            div_q     <= div_d;
            visible_q <= visible_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
        end
    end

    assign visible_o             = visible_q;
    assign end_of_visible_line_o = eol_q;
    assign end_of_frame_o        = eof_q;
    assign hsync_n_o             = hsync_n_q;
    assign vsync_n_o             = vsync_n_q;

`ifdef VIDEO_TIMING_COORDS_EN
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;

    // Captured on the tick so they line up with the visible_o strobe.
    always_comb begin
        x_d = tick ? h_pos : x_q;
        y_d = tick ? v_pos : y_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`else
    logic unused_axis;
    assign unused_axis = ^{v_wrap, v_pos};
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench: two small-raster instances (2 and 1 clocks per pixel) checked cycle by cycle.
module tb_video_timing_generator;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = 15;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = 8;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic eof2, eol2, hs2, vs2, vis2;
    logic eof1, eol1, hs1, vs1, vis1;
`ifdef VIDEO_TIMING_COORDS_EN
    logic [3:0] x2, x1;
    logic [2:0] y2, y1;
`endif

    video_timing_generator #(
        .CLKS_PER_PIXEL(2),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut2 (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .end_of_frame_o        (eof2),
        .end_of_visible_line_o (eol2),
        .hsync_n_o             (hs2),
        .vsync_n_o             (vs2),
        .visible_o             (vis2)
`ifdef VIDEO_TIMING_COORDS_EN
        ,
        .x_o                   (x2),
        .y_o                   (y2)
`endif
    );

    video_timing_generator #(
        .CLKS_PER_PIXEL(1),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut1 (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .end_of_frame_o        (eof1),
        .end_of_visible_line_o (eol1),
        .hsync_n_o             (hs1),
        .vsync_n_o             (vs1),
        .visible_o             (vis1)
`ifdef VIDEO_TIMING_COORDS_EN
        ,
        .x_o                   (x1),
        .y_o                   (y1)
`endif
    );

    // Expected {visible, eol, eof, hsync_n, vsync_n} and position at cycle c after release.
    function automatic void expect_at(input int c, input int cpp,
                                      output logic [4:0] vec, output int ex, output int ey);
        int k, h, v;
        logic strobe;
        vec = 5'b00011;
        ex  = 0;
        ey  = 0;
        if (c >= cpp) begin
            k      = c / cpp - 1;
            h      = k % HT;
            v      = (k / HT) % VT;
            strobe = ((c % cpp) == 0);
            vec[4] = strobe && (h < HV) && (v < VV);
            vec[3] = strobe && (h == HV) && (v < VV);
            vec[2] = strobe && (h == 0) && (v == VV);
            vec[1] = !((h >= HV + HF) && (h < HV + HF + HS));
            vec[0] = !((v >= VV + VF) && (v < VV + VF + VS));
            ex     = h;
            ey     = v;
        end
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({vis2, eol2, eof2, hs2, vs2} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_dut2: got %b want 00011", {vis2, eol2, eof2, hs2, vs2});
        end
        checks++;
        if ({vis1, eol1, eof1, hs1, vs1} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_dut1: got %b want 00011", {vis1, eol1, eof1, hs1, vs1});
        end
`ifdef VIDEO_TIMING_COORDS_EN
        checks++;
        if ({x2, y2, x1, y1} !== 14'd0) begin
            errors++;
            $display("FAIL reset_coords: got x2=%0d y2=%0d x1=%0d y1=%0d want 0", x2, y2, x1, y1);
        end
`endif
        rst_i = 1'b0;
    endtask

    task automatic test_frames();
        logic [4:0] e;
        int ex, ey;
        int first_vis2 = -1, first_eol2 = -1, first_vis1 = -1, first_eol1 = -1;
        int n_vis2 = 0, n_eol2 = 0, n_vis1 = 0, n_eol1 = 0, n_eof1 = 0;
        int eof2_a = -1, eof2_b = -1, n_eof2 = 0, eof1_a = -1, eof1_b = -1;
        int hs_low2 = 0, vs_low2 = 0, run1 = 0, max_run1 = 0;
        int last_x2 = -1, last_y2 = -1;
        for (int c = 0; c < 370; c++) begin
            expect_at(c, 2, e, ex, ey);
            checks++;
            if ({vis2, eol2, eof2, hs2, vs2} !== e) begin
                errors++;
                $display("FAIL cycle_dut2 c=%0d: got %b want %b", c, {vis2, eol2, eof2, hs2, vs2}, e);
            end
`ifdef VIDEO_TIMING_COORDS_EN
            if (vis2) begin
                checks++;
                if (x2 !== 4'(ex) || y2 !== 3'(ey)) begin
                    errors++;
                    $display("FAIL coords_dut2 c=%0d: got (%0d,%0d) want (%0d,%0d)", c, x2, y2, ex, ey);
                end
                if (c < 240) begin
                    last_x2 = int'(x2);
                    last_y2 = int'(y2);
                end
            end
`endif
            if (c < 240) begin
                if (vis2) begin
                    n_vis2++;
                    if (first_vis2 < 0) first_vis2 = c;
                end
                if (eol2) begin
                    n_eol2++;
                    if (first_eol2 < 0) first_eol2 = c;
                end
                if (!hs2) hs_low2++;
                if (!vs2) vs_low2++;

                expect_at(c, 1, e, ex, ey);
                checks++;
                if ({vis1, eol1, eof1, hs1, vs1} !== e) begin
                    errors++;
                    $display("FAIL cycle_dut1 c=%0d: got %b want %b", c, {vis1, eol1, eof1, hs1, vs1}, e);
                end
`ifdef VIDEO_TIMING_COORDS_EN
                if (vis1) begin
                    checks++;
                    if (x1 !== 4'(ex) || y1 !== 3'(ey)) begin
                        errors++;
                        $display("FAIL coords_dut1 c=%0d: got (%0d,%0d) want (%0d,%0d)", c, x1, y1, ex, ey);
                    end
                end
`endif
                if (vis1) begin
                    n_vis1++;
                    run1++;
                    if (first_vis1 < 0) first_vis1 = c;
                    if (run1 > max_run1) max_run1 = run1;
                end else begin
                    run1 = 0;
                end
                if (eol1) begin
                    n_eol1++;
                    if (first_eol1 < 0) first_eol1 = c;
                end
                if (eof1) begin
                    n_eof1++;
                    if (eof1_a < 0) eof1_a = c; else eof1_b = c;
                end
            end
            if (eof2) begin
                n_eof2++;
                if (eof2_a < 0) eof2_a = c; else eof2_b = c;
            end
            @(posedge clk);
            #1;
        end

        checks++;
        if (first_vis2 != 2) begin errors++; $display("FAIL first_vis2: got %0d want 2", first_vis2); end
        checks++;
        if (first_eol2 != 18) begin errors++; $display("FAIL first_eol2: got %0d want 18", first_eol2); end
        checks++;
        if (n_vis2 != 32) begin errors++; $display("FAIL frame_vis2: got %0d want 32", n_vis2); end
        checks++;
        if (n_eol2 != 4) begin errors++; $display("FAIL frame_eol2: got %0d want 4", n_eol2); end
        checks++;
        if (n_eof2 != 2 || eof2_a != 122 || eof2_b != 362) begin
            errors++;
            $display("FAIL eof2: got n=%0d at %0d,%0d want 2 at 122,362", n_eof2, eof2_a, eof2_b);
        end
        checks++;
        if (hs_low2 != 48) begin errors++; $display("FAIL hsync_low2: got %0d want 48", hs_low2); end
        checks++;
        if (vs_low2 != 60) begin errors++; $display("FAIL vsync_low2: got %0d want 60", vs_low2); end
        checks++;
        if (first_vis1 != 1 || first_eol1 != 9) begin
            errors++;
            $display("FAIL first_dut1: got vis=%0d eol=%0d want 1,9", first_vis1, first_eol1);
        end
        checks++;
        if (n_vis1 != 64 || n_eol1 != 8) begin
            errors++;
            $display("FAIL frames_dut1: got vis=%0d eol=%0d want 64,8", n_vis1, n_eol1);
        end
        checks++;
        if (max_run1 != 8) begin errors++; $display("FAIL run_dut1: got %0d want 8", max_run1); end
        checks++;
        if (n_eof1 != 2 || eof1_a != 61 || eof1_b != 181) begin
            errors++;
            $display("FAIL eof1: got n=%0d at %0d,%0d want 2 at 61,181", n_eof1, eof1_a, eof1_b);
        end
`ifdef VIDEO_TIMING_COORDS_EN
        checks++;
        if (last_x2 != 7 || last_y2 != 3) begin
            errors++;
            $display("FAIL last_pixel: got (%0d,%0d) want (7,3)", last_x2, last_y2);
        end
`endif
    endtask

    task automatic test_mid_reset();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (55) begin
            @(posedge clk);
            #1;
        end
        // Cycle 55: pixel (11,1) is inside the hsync window on dut2.
        checks++;
        if (hs2 !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync: got %b want 0", hs2); end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({vis2, eol2, eof2, hs2, vs2, vis1, eol1, eof1, hs1, vs1} !== 10'b0001100011) begin
            errors++;
            $display("FAIL mid_reset: got %b want 0001100011",
                     {vis2, eol2, eof2, hs2, vs2, vis1, eol1, eof1, hs1, vs1});
        end
        rst_i = 1'b0;
        checks++;
        if ({vis2, vis1} !== 2'b00) begin errors++; $display("FAIL restart_c0: got %b want 00", {vis2, vis1}); end
        @(posedge clk);
        #1;
        checks++;
        if ({vis2, vis1} !== 2'b01) begin errors++; $display("FAIL restart_c1: got %b want 01", {vis2, vis1}); end
`ifdef VIDEO_TIMING_COORDS_EN
        checks++;
        if (x1 !== 4'd0 || y1 !== 3'd0) begin
            errors++;
            $display("FAIL restart_xy1: got (%0d,%0d) want (0,0)", x1, y1);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if ({vis2, eol2, eof2, hs2, vs2} !== 5'b10011) begin
            errors++;
            $display("FAIL restart_c2: got %b want 10011", {vis2, eol2, eof2, hs2, vs2});
        end
`ifdef VIDEO_TIMING_COORDS_EN
        checks++;
        if (x2 !== 4'd0 || y2 !== 3'd0) begin
            errors++;
            $display("FAIL restart_xy2: got (%0d,%0d) want (0,0)", x2, y2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frames();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Produces the raster timing that drives the colour-bar generator and later pixel sources: active-low sync levels, a per-pixel `visible` strobe, and single-cycle end-of-visible-line and end-of-frame pulses. It runs on the system clock with an internal pixel prescaler, so one pixel is issued every `CLKS_PER_PIXEL` cycles. It is the first stage of the video pipeline; its outputs connect directly to the `*_i` timing inputs of the next stage.

## Interface
- `CLKS_PER_PIXEL`, 2: system clocks per pixel, ≥1
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal pixels per region
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical lines per region
- `clk_i` in 1: system clock; the block uses this single clock only
- `rst_i` in 1: synchronous, active-high reset
- `end_of_frame_o` out 1: one-cycle pulse at the start of the vertical front porch
- `end_of_visible_line_o` out 1: one-cycle pulse after the last visible pixel of each visible line
- `hsync_n_o` out 1: active-low horizontal sync level
- `vsync_n_o` out 1: active-low vertical sync level
- `visible_o` out 1: one-cycle strobe per visible pixel
- `x_o` out `$clog2(H_TOTAL)`: x position of the current strobe (only with `VIDEO_TIMING_COORDS_EN`)
- `y_o` out `$clog2(V_TOTAL)`: y position of the current strobe (only with `VIDEO_TIMING_COORDS_EN`)

## Operation
- Totals: `H_TOTAL` = sum of the four H regions (800); `V_TOTAL` = sum of the four V regions (525).
- Prescaler `div` counts 0..`CLKS_PER_PIXEL`-1 and wraps. A tick occurs on the cycle where `div`==`CLKS_PER_PIXEL`-1. With `CLKS_PER_PIXEL`=1, every cycle is a tick.
- On each tick the current position (`h`,`v`) is decoded into registered outputs, then `h` advances.
  - `h` wraps from `H_TOTAL`-1 to 0. On that wrap, `v` advances.
  - `v` wraps from `V_TOTAL`-1 to 0.
- Decode of position (`h`,`v`):
  - visible region: `h`<`H_VISIBLE` and `v`<`V_VISIBLE`
  - `hsync_n` is 0 when `h` is in [`H_VISIBLE`+`H_FRONT`, `H_VISIBLE`+`H_FRONT`+`H_SYNC`-1] (656..751)
  - `vsync_n` is 0 when `v` is in [`V_VISIBLE`+`V_FRONT`, `V_VISIBLE`+`V_FRONT`+`V_SYNC`-1] (490..491), for whole lines
  - `end_of_visible_line` fires when `h`==`H_VISIBLE` and `v`<`V_VISIBLE`
  - `end_of_frame` fires when `h`==0 and `v`==`V_VISIBLE`
- Output behaviour:
  - Strobes (`visible_o`, `end_of_visible_line_o`, `end_of_frame_o`) are high only on the cycle after a tick, and low on every other cycle.
  - Sync levels are updated on the cycle after a tick and held between ticks.
- Reset values:
  - `div`=0, `h`=0, `v`=0
  - `hsync_n_o`=1, `vsync_n_o`=1
  - `visible_o`=0, `end_of_visible_line_o`=0, `end_of_frame_o`=0
  - `x_o`=0, `y_o`=0
- Reset mid-frame: all state returns to the reset values on the next edge, with no partial pulse. The raster restarts at (0,0).
- `end_of_visible_line_o` and `visible_o` are never high in the same cycle.

## Timing
- Cycle 0 is the first cycle with `rst_i`=0. The first tick occurs at cycle `CLKS_PER_PIXEL`-1. Outputs for pixel (0,0) appear at cycle `CLKS_PER_PIXEL`.
- Latency from tick to output is 1 cycle for every output.
- Line period is `H_TOTAL`×`CLKS_PER_PIXEL` cycles (1600 at defaults). Frame period is that × `V_TOTAL` (840 000).
- Parameters are static; there is no runtime mode change.

## Configuration
- Macro `VIDEO_TIMING_COORDS_EN`:
  - Defined: `x_o`/`y_o` are registered copies of `h`/`v`, valid on the same cycle as `visible_o`.
  - Undefined: the ports and their registers are absent; all other behaviour is identical.

## Structure
- Package `video_timing_pkg` holds:
  - 640×480 mode constants (the eight region sizes)
  - derived `H_TOTAL`/`V_TOTAL`
  - the counter width functions
- Sub-module `video_timing_axis`, instantiated twice (H and V). It contains an advance-enable counter with wrap, the active flag, the sync flag, and the wrap flag.

## Test plan
- Reset release, `CLKS_PER_PIXEL`=2 → first `visible_o` at cycle 2; 640 `visible_o` strobes on line 0, spaced 2 cycles apart; `end_of_visible_line_o` at cycle 1282.
- One full frame → exactly 307 200 `visible_o`, 480 `end_of_visible_line_o`, and 1 `end_of_frame_o` (at line 480, h=0).
- Sync windows → `hsync_n_o` low for 96 pixels starting at h=656 on every line; `vsync_n_o` low on lines 490–491 only.
- `rst_i` pulsed at line 200, h=300 → all outputs return to reset values next cycle; the next `visible_o` is pixel (0,0) at cycle 2 after release.
- `CLKS_PER_PIXEL`=1 → `visible_o` is high continuously for 640 cycles per visible line; frame period is 420 000 cycles.
- `VIDEO_TIMING_COORDS_EN` defined → at each `visible_o`, `x_o`/`y_o` match the strobe's position; last visible pixel reads (639,479).
